// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-macro SRAM port arbiter.
// Default widths match one SRAM_wrapper macro: 2 ports, 14-bit word address, 32-bit data.
package sram_arb_pkg;

  localparam int unsigned SRAM_NUM_PORTS = 2;
  localparam int unsigned SRAM_AW        = 14;
  localparam int unsigned SRAM_DW        = 32;
  localparam int unsigned SRAM_PW        = (SRAM_NUM_PORTS > 1) ? $clog2(SRAM_NUM_PORTS) : 1;

  localparam logic [SRAM_DW-1:0] SRAM_IDLE_BWEB = '1;
  localparam logic               SRAM_RD        = 1'b1;

  typedef logic [SRAM_PW-1:0] port_id_t;

  typedef struct packed {
    logic               web;
    logic [SRAM_DW-1:0] bweb;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Request vector -> one-hot grant plus grant index, round-robin by default.
// FIXED_PRIO=1 (set by SRAM_ARB_FIXED_PRIO_EN in the top) selects lowest-index-wins with no pointer.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned N          = SRAM_NUM_PORTS,
  parameter bit          FIXED_PRIO = 1'b0,
  localparam int unsigned PW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_id
);

  generate
    if (FIXED_PRIO) begin : g_fixed
      logic w_found;
      logic w_unused;
      assign w_unused = clk ^ rst;

      always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
          if (!w_found && i_req[i]) begin
            w_found     = 1'b1;
            o_gnt[i]    = 1'b1;
            o_gnt_id    = PW'(i);
          end
        end
      end
    end else begin : g_rr
      logic [PW-1:0] r_ptr;
      logic          w_found;
      int            w_idx;

      always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < int'(N); i++) begin
          // Explicit wrap keeps non-power-of-2 port counts inside 0..N-1.
          w_idx = int'(r_ptr) + i;
          if (w_idx >= int'(N)) w_idx = w_idx - int'(N);
          if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_id     = PW'(w_idx);
          end
        end
      end

      // Any request is a grant and every grant is accepted, so |i_req marks an accept.
      always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
          r_ptr <= '0;
        end else if (|i_req) begin
          r_ptr <= (o_gnt_id == PW'(N - 1)) ? '0 : o_gnt_id + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM_wrapper macro among NUM_PORTS requesters, one access per cycle, response latency 1.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = SRAM_NUM_PORTS,
  parameter int unsigned AW        = SRAM_AW,
  parameter int unsigned DW        = SRAM_DW,
  localparam int unsigned PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS-1:0]    req_web,
  input  logic [NUM_PORTS*DW-1:0] req_bweb,
  input  logic [NUM_PORTS*AW-1:0] req_addr,
  input  logic [NUM_PORTS*DW-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    sram_ceb,
  output logic                    sram_web,
  output logic [DW-1:0]           sram_bweb,
  output logic [AW-1:0]           sram_a,
  output logic [DW-1:0]           sram_di,
  input  logic [DW-1:0]           sram_do
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [PW-1:0]        w_gnt_id;
  logic                 w_acc;

  logic                 r_pend;
  logic [PW-1:0]        r_port;
  logic                 r_rd;

  // Reset masks requests combinationally so the macro is deselected the moment rst rises.
  assign w_req     = rst ? '0 : req_valid;
  assign w_acc     = |w_req;
  assign req_ready = w_gnt;

  rr_arbiter #(
    .N          (NUM_PORTS),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = SRAM_RD;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (w_acc) begin
      sram_ceb  = 1'b0;
      sram_web  = req_web[w_gnt_id];
      sram_bweb = req_bweb[int'(w_gnt_id)*DW +: DW];
      sram_a    = req_addr[int'(w_gnt_id)*AW +: AW];
      sram_di   = req_wdata[int'(w_gnt_id)*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_port <= '0;
      r_rd   <= 1'b0;
    end else begin
      r_pend <= w_acc;
      if (w_acc) begin
        r_port <= w_gnt_id;
        r_rd   <= (sram_web == SRAM_RD);
      end
    end
  end

  // The macro presents read data the cycle after the access, aligned with the pending register.
  always_comb begin
    rsp_valid = '0;
    if (r_pend) rsp_valid[r_port] = 1'b1;
    rsp_rdata = (r_pend && r_rd) ? sram_do : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM macro model.
// Honours SRAM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NP = 2;
  localparam int AW = 14;
  localparam int DW = 32;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_web;
  logic [NP*DW-1:0] req_bweb;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             sram_ceb;
  logic             sram_web;
  logic [DW-1:0]    sram_bweb;
  logic [AW-1:0]    sram_a;
  logic [DW-1:0]    sram_di;
  logic [DW-1:0]    sram_do;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt0  = 0;
  int   cnt1  = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_web   (req_web),
    .req_bweb  (req_bweb),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_bweb (sram_bweb),
    .sram_a    (sram_a),
    .sram_di   (sram_di),
    .sram_do   (sram_do)
  );

  // Behavioural macro: bit-masked write, registered read data.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (sram_web) sram_do <= mem[sram_a];
      else          mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic web, input logic [31:0] bweb,
                          input logic [13:0] addr, input logic [31:0] wdata);
    req_web[p]            = web;
    req_bweb[p*DW +: DW]  = bweb;
    req_addr[p*AW +: AW]  = addr;
    req_wdata[p*DW +: DW] = wdata;
  endtask

  // Presents one request on port p for one cycle; the port is expected to win immediately.
  task automatic issue(input int p, input logic web, input logic [31:0] bweb, input logic [13:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input bit push);
    logic [NP-1:0] oh;
    @(posedge clk); #1;
    set_port(p, web, bweb, addr, wdata);
    req_valid    = '0;
    req_valid[p] = 1'b1;
    oh           = '0;
    oh[p]        = 1'b1;
    @(negedge clk);
    check("req_ready", req_ready, oh);
    check("sram_ceb", sram_ceb, 1'b0);
    check("sram_a", sram_a, addr);
    check("sram_web", sram_web, web);
    if (push) sb.push_back('{p, web ? exp_rd : 32'h0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = '0;
    end
  endtask

  // Monitor: every response pulse pops the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, '0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", rsp_valid, NP'(1) << e.port);
          check("rsp_rdata", rsp_rdata, e.data);
        end
        if (rsp_valid[0] === 1'b1) cnt0++;
        if (rsp_valid[1] === 1'b1) cnt1++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    rst       = 1'b1;
    req_valid = '0;
    req_web   = '1;
    req_bweb  = '1;
    req_addr  = '0;
    req_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ceb", sram_ceb, 1'b1);
    check("rst_web", sram_web, 1'b1);
    check("rst_bweb", sram_bweb, SRAM_IDLE_BWEB);
    check("rst_a", sram_a, '0);
    check("rst_di", sram_di, '0);
    check("rst_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rdata", rsp_rdata, '0);
    #2 rst = 1'b0;

    // Full-word write then read, port 1.
    issue(1, 1'b0, 32'h0, 14'h0010, 32'hDEADBEEF, 32'h0, 1'b1);
    issue(1, 1'b1, 32'hFFFFFFFF, 14'h0010, 32'h0, 32'hDEADBEEF, 1'b1);

    // Byte write merges into the existing word.
    issue(1, 1'b0, 32'h0, 14'h0020, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1, 1'b0, 32'hFFFF00FF, 14'h0020, 32'h00001200, 32'h0, 1'b1);
    issue(1, 1'b1, 32'hFFFFFFFF, 14'h0020, 32'h0, 32'hFFFF12FF, 1'b1);

    // Back-to-back on port 0: fill 0..7, then read them on consecutive cycles.
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'h0, 14'(i), 32'hA5000000 + 32'(i), 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'hFFFFFFFF, 14'(i), 32'h0, 32'hA5000000 + 32'(i), 1'b1);

    // Port 1 wins, pointer parks at 0 across idle cycles.
    issue(1, 1'b0, 32'h0, 14'h0030, 32'h00000001, 32'h0, 1'b1);
    idle(5);

    // Contention: both ports hold reads for 12 cycles.
    b0 = cnt0;
    b1 = cnt1;
    for (int k = 0; k < 12; k++) begin
      int g;
      @(posedge clk); #1;
      set_port(0, 1'b1, 32'hFFFFFFFF, 14'h0003, 32'h0);
      set_port(1, 1'b1, 32'hFFFFFFFF, 14'h0010, 32'h0);
      req_valid = 2'b11;
      g = FIXED ? 0 : (k % 2);
      @(negedge clk);
      check("contend_ready", req_ready, NP'(1) << g);
      sb.push_back('{g, (g == 0) ? 32'hA5000003 : 32'hDEADBEEF});
    end
    idle(3);
    check("contend_cnt0", 64'(cnt0 - b0), FIXED ? 64'd12 : 64'd6);
    check("contend_cnt1", 64'(cnt1 - b1), FIXED ? 64'd0 : 64'd6);

    // Reset mid-access: accepted read must never respond; pointer restarts at 0.
    issue(0, 1'b1, 32'hFFFFFFFF, 14'h0005, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    set_port(1, 1'b1, 32'hFFFFFFFF, 14'h0010, 32'h0);
    req_valid = 2'b11;
    #1;
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_ceb", sram_ceb, 1'b1);
    check("midrst_ready", req_ready, '0);
    @(negedge clk);
    check("midrst_rsp_valid_hold", rsp_valid, '0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    sb.push_back('{0, 32'hA5000005});
    @(posedge clk); #1;
    req_valid = '0;
    idle(3);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
